// File: rtl/ad9643_rx_pkg.sv
// ad9643_rx_pkg: shared types and constants for the AD9643 fabric receiver.
// Contents:
//   rx_state_t - lock FSM state encoding (2 bits; encodings 2 and 3 unused)
//   AD9643_DW  - native sample width of the AD9643 LVDS bus
package ad9643_rx_pkg;

    typedef enum logic [1:0] {
        RX_SEARCH = 2'd0,
        RX_LOCKED = 2'd1
    } rx_state_t;

    localparam int AD9643_DW = 14;

endpackage

// File: rtl/ad9643_rx_if.sv
// ad9643_rx_if: sample bus between the capture front end and the receiver.
// Signals:
//   in_valid/in_p/in_n/in_or   - captured sample (true word, complement word, overrange)
//   adc_valid/adc_data/adc_or  - forwarded sample, one clock later
// Modports:
//   master - drives the captured sample, observes the forwarded sample
//   slave  - the receiver: consumes the captured sample, drives the forwarded one
interface ad9643_rx_if
    import ad9643_rx_pkg::*;
#(
    parameter int DW = AD9643_DW
);

    logic          in_valid;
    logic [DW-1:0] in_p;
    logic [DW-1:0] in_n;
    logic          in_or;
    logic          adc_valid;
    logic [DW-1:0] adc_data;
    logic          adc_or;

    modport master (
        output in_valid, in_p, in_n, in_or,
        input  adc_valid, adc_data, adc_or
    );

    modport slave (
        input  in_valid, in_p, in_n, in_or,
        output adc_valid, adc_data, adc_or
    );

endinterface

// File: rtl/ad9643_rx_pattern_chk.sv
// ad9643_pattern_chk: per-sample quality check for the AD9643 receiver.
// Holds the previous valid true word and flags each sample as good when its
// complement word is the exact inverse and, with test_en set, the true word
// continues an incrementing ramp (wrapping from all-ones to zero).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   in_valid  - sample present this cycle
//   in_p/in_n - true and complement words
//   test_en   - enable the ramp check
//   good      - combinational verdict for the current sample
module ad9643_pattern_chk
    import ad9643_rx_pkg::*;
#(
    parameter int DW = AD9643_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_p,
    input  logic [DW-1:0] in_n,
    input  logic          test_en,
    output logic          good
);

    logic [DW-1:0] prev_p_r;
    logic          prev_valid_r;
    logic          comp_ok_s;
    logic          ramp_ok_s;

    // Remember every valid true word, good or bad, so one glitch costs at most two bad samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_p_r     <= {DW{1'b0}};
            prev_valid_r <= 1'b0;
        end else if (in_valid) begin
            prev_p_r     <= in_p;
            prev_valid_r <= 1'b1;
        end
    end

    // Complement and ramp checks; the first sample after reset has no predecessor and passes the ramp check.
    always_comb begin
        comp_ok_s = (in_n == ~in_p);
        ramp_ok_s = !prev_valid_r || (in_p == DW'(prev_p_r + DW'(1)));
        good      = comp_ok_s && (!test_en || ramp_ok_s);
    end

endmodule

// File: rtl/ad9643_rx.sv
// ad9643_rx: fabric-side receiver for the AD9643 parallel LVDS bus.
// Forwards every captured sample with one cycle of latency, runs a lock FSM
// driven by the pattern checker and counts bad samples seen while locked.
// Ports:
//   clk, rst   - receive clock, synchronous active-high reset
//   bus        - sample bus (slave side): in_* consumed, adc_* produced
//   test_en    - 1 enables the incrementing-ramp check
//   err_clr    - single-cycle pulse clearing err_cnt (wins over an increment)
//   locked     - FSM is in LOCKED
//   lost_lock  - one-cycle pulse on LOCKED -> SEARCH
//   err_cnt    - saturating count of bad samples while LOCKED
//   state_o    - current FSM state for debug
module ad9643_rx
    import ad9643_rx_pkg::*;
#(
    parameter int DW       = AD9643_DW,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    ad9643_rx_if.slave       bus,
    input  logic             test_en,
    input  logic             err_clr,
    output logic             locked,
    output logic             lost_lock,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state_o
);

    localparam logic [7:0] LOCK_THR = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_THR = 8'(LOSS_CNT);

    rx_state_t        state_r;
    rx_state_t        state_nxt_s;
    logic [7:0]       good_run_r;
    logic [7:0]       good_run_nxt_s;
    logic [7:0]       bad_run_r;
    logic [7:0]       bad_run_nxt_s;
    logic [ERR_W-1:0] err_cnt_r;
    logic [ERR_W-1:0] err_cnt_nxt_s;
    logic             lost_nxt_s;
    logic             good_s;

    logic             adc_valid_r;
    logic [DW-1:0]    adc_data_r;
    logic             adc_or_r;
    logic             locked_r;
    logic             lost_lock_r;

    ad9643_pattern_chk #(
        .DW (DW)
    ) u_pattern_chk (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_p     (bus.in_p),
        .in_n     (bus.in_n),
        .test_en  (test_en),
        .good     (good_s)
    );

    // Lock FSM next-state, run counters and error counter; nothing moves without a valid sample.
    always_comb begin
        state_nxt_s    = state_r;
        good_run_nxt_s = good_run_r;
        bad_run_nxt_s  = bad_run_r;
        err_cnt_nxt_s  = err_cnt_r;
        lost_nxt_s     = 1'b0;
        case (state_r)
            RX_SEARCH: begin
                if (bus.in_valid) begin
                    if (good_s) begin
                        if (good_run_r + 8'd1 == LOCK_THR) begin
                            state_nxt_s    = RX_LOCKED;
                            good_run_nxt_s = 8'd0;
                        end else begin
                            good_run_nxt_s = good_run_r + 8'd1;
                        end
                    end else begin
                        good_run_nxt_s = 8'd0;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RX_LOCKED: begin
                if (bus.in_valid) begin
                    if (good_s) begin
                        bad_run_nxt_s = 8'd0;
                    end else begin
                        if (err_cnt_r != {ERR_W{1'b1}}) begin
                            err_cnt_nxt_s = err_cnt_r + ERR_W'(1);
                        end else begin
                            err_cnt_nxt_s = err_cnt_r;
                        end
                        if (bad_run_r + 8'd1 == LOSS_THR) begin
                            state_nxt_s    = RX_SEARCH;
                            bad_run_nxt_s  = 8'd0;
                            good_run_nxt_s = 8'd0;
                            lost_nxt_s     = 1'b1;
                        end else begin
                            bad_run_nxt_s = bad_run_r + 8'd1;
                        end
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                // Unused encodings recover to a clean search.
                state_nxt_s    = RX_SEARCH;
                good_run_nxt_s = 8'd0;
                bad_run_nxt_s  = 8'd0;
            end
        endcase
        if (err_clr) begin
            err_cnt_nxt_s = {ERR_W{1'b0}};
        end else begin
            err_cnt_nxt_s = err_cnt_nxt_s;
        end
    end

    // State, counters and all output registers; reset never produces a lost_lock pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RX_SEARCH;
            good_run_r  <= 8'd0;
            bad_run_r   <= 8'd0;
            err_cnt_r   <= {ERR_W{1'b0}};
            adc_valid_r <= 1'b0;
            adc_data_r  <= {DW{1'b0}};
            adc_or_r    <= 1'b0;
            locked_r    <= 1'b0;
            lost_lock_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            good_run_r  <= good_run_nxt_s;
            bad_run_r   <= bad_run_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
            adc_valid_r <= bus.in_valid;
            adc_data_r  <= bus.in_p;
            adc_or_r    <= bus.in_or;
            locked_r    <= (state_nxt_s == RX_LOCKED);
            lost_lock_r <= lost_nxt_s;
        end
    end

    assign bus.adc_valid = adc_valid_r;
    assign bus.adc_data  = adc_data_r;
    assign bus.adc_or    = adc_or_r;
    assign locked        = locked_r;
    assign lost_lock     = lost_lock_r;
    assign err_cnt       = err_cnt_r;
    assign state_o       = state_r;

endmodule
